// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: flow control from ID, instruction-memory handshake and the
// head entry presented to ID. The master side is the fetch unit.
interface if_fetch_if;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [63:0] imem_rdata_i;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [63:0] id_inst_o;

   modport master (
      input  stall_i, flush_i, flush_pc_i, imem_ack_i, imem_rdata_i,
      output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
   );

   modport slave (
      output stall_i, flush_i, flush_pc_i, imem_ack_i, imem_rdata_i,
      input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: keeps at most one memory request in flight and buffers fetched
// words in a 2-entry FIFO toward ID. A flush redirects fetch and drops everything
// buffered; a request that is already in flight is waited out and its data dropped.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 8
) (
   input logic       clk,
   input logic       rst,
   if_fetch_if.master bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

   state_e      state_q;
   logic        req_q;
   logic [31:0] addr_q;
   logic [31:0] fetch_pc_q;
   logic [31:0] fetch_pc_inc;
   logic [1:0]  count_q;
   logic [1:0]  count_d;
   logic [31:0] pc_q   [2];
   logic [63:0] inst_q [2];

   logic ack;
   logic push;
   logic pop;
   logic can_issue;
   logic wr_hi;

   assign bus.imem_req_o  = req_q;
   assign bus.imem_addr_o = addr_q;
   assign bus.id_valid_o  = (count_q != 2'd0);
   assign bus.id_pc_o     = pc_q[0];
   assign bus.id_inst_o   = inst_q[0];

   // Handshake decode and next occupancy, including same-edge push and pop.
   always_comb begin
      ack          = req_q & bus.imem_ack_i;
      pop          = (count_q != 2'd0) & ~bus.stall_i & ~bus.flush_i;
      push         = (state_q == StFetch) & ack & ~bus.flush_i;
      count_d      = bus.flush_i ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});
      // Never issue a request that could land in a full FIFO.
      can_issue    = (count_d <= 2'd1);
      // Incoming word goes to slot 1 only if slot 0 stays occupied after this edge.
      wr_hi        = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
      fetch_pc_inc = fetch_pc_q + 32'(PC_STEP);
   end

   // FIFO storage and occupancy; slot 0 is always the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 2'd0;
         pc_q[0]   <= '0;
         pc_q[1]   <= '0;
         inst_q[0] <= '0;
         inst_q[1] <= '0;
      end else begin
         count_q <= count_d;
         if (pop) begin
            pc_q[0]   <= pc_q[1];
            inst_q[0] <= inst_q[1];
         end
         if (push) begin
            if (wr_hi) begin
               pc_q[1]   <= addr_q;
               inst_q[1] <= bus.imem_rdata_i;
            end else begin
               pc_q[0]   <= addr_q;
               inst_q[0] <= bus.imem_rdata_i;
            end
         end
      end
   end

   // Request FSM; the request and address are held until the ack edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         addr_q     <= '0;
         fetch_pc_q <= RESET_PC;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.flush_i) begin
                  fetch_pc_q <= bus.flush_pc_i;
               end else if (can_issue) begin
                  req_q      <= 1'b1;
                  addr_q     <= fetch_pc_q;
                  fetch_pc_q <= fetch_pc_inc;
                  state_q    <= StFetch;
               end
            end
            StFetch: begin
               if (bus.flush_i) begin
                  fetch_pc_q <= bus.flush_pc_i;
                  if (ack) begin
                     req_q   <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StDiscard;
                  end
               end else if (ack) begin
                  if (can_issue) begin
                     addr_q     <= fetch_pc_q;
                     fetch_pc_q <= fetch_pc_inc;
                  end else begin
                     req_q   <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            StDiscard: begin
               if (bus.flush_i) begin
                  fetch_pc_q <= bus.flush_pc_i;
               end
               if (ack) begin
                  req_q   <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a cycle table for streaming and stall, directed flush/reset
// sequences, and a randomized run checked against an in-order PC stream model.
module tb_if_fetch;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   if_fetch_if bus ();
   if_fetch_if wbus ();

   if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(8)) dut_wrap (
      .clk(clk),
      .rst(rst),
      .bus(wbus)
   );

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hDEAD_BEEF, ~a};
   endfunction

   // Memory contents are a fixed function of the address.
   assign bus.imem_rdata_i  = mem_word(bus.imem_addr_o);
   assign wbus.imem_rdata_i = mem_word(wbus.imem_addr_o);
   assign wbus.imem_ack_i   = wbus.imem_req_o;
   assign wbus.stall_i      = 1'b0;
   assign wbus.flush_i      = 1'b0;
   assign wbus.flush_pc_i   = 32'h0;

   typedef struct {
      logic        stall;
      logic        ack;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t vt [15];

   function automatic vec_t v(input logic s, input logic a, input logic rq,
                              input logic [31:0] ad, input logic vl, input logic [31:0] p);
      vec_t r;
      r.stall = s; r.ack = a; r.req = rq; r.addr = ad; r.valid = vl; r.pc = p;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] fp,
                        input logic a);
      rst = r; bus.stall_i = s; bus.flush_i = f; bus.flush_pc_i = fp; bus.imem_ack_i = a;
   endtask

   task automatic expect_req(input string n, input logic rq, input logic [31:0] ad);
      check({n, " req"}, bus.imem_req_o, rq);
      if (rq) check({n, " addr"}, bus.imem_addr_o, ad);
   endtask

   task automatic expect_head(input string n, input logic vl, input logic [31:0] p);
      check({n, " valid"}, bus.id_valid_o, vl);
      if (vl) begin
         check({n, " pc"}, bus.id_pc_o, p);
         check({n, " inst"}, bus.id_inst_o, mem_word(p));
      end
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] prev_addr;
      logic [31:0] r32;
      logic [31:0] fp;
      logic        prev_req, prev_ack, a, s, f;
      int          lat, pops;

      // Streaming with same-cycle acks, then a 5-cycle stall and recovery.
      vt[0]  = v(0, 0, 0, 32'h00, 0, 32'h00);
      vt[1]  = v(0, 1, 1, 32'h00, 0, 32'h00);
      vt[2]  = v(0, 1, 1, 32'h08, 1, 32'h00);
      vt[3]  = v(0, 1, 1, 32'h10, 1, 32'h08);
      vt[4]  = v(1, 1, 1, 32'h18, 1, 32'h10);
      vt[5]  = v(1, 0, 0, 32'h00, 1, 32'h10);
      vt[6]  = v(1, 0, 0, 32'h00, 1, 32'h10);
      vt[7]  = v(1, 0, 0, 32'h00, 1, 32'h10);
      vt[8]  = v(1, 0, 0, 32'h00, 1, 32'h10);
      vt[9]  = v(0, 0, 0, 32'h00, 1, 32'h10);
      vt[10] = v(0, 1, 1, 32'h20, 1, 32'h18);
      vt[11] = v(0, 0, 1, 32'h28, 1, 32'h20);
      vt[12] = v(0, 0, 1, 32'h28, 0, 32'h00);
      vt[13] = v(0, 1, 1, 32'h28, 0, 32'h00);
      vt[14] = v(0, 0, 1, 32'h30, 1, 32'h28);

      drive(1, 0, 0, 32'h0, 0);
      tick(); tick();
      check("reset req", bus.imem_req_o, 1'b0);
      check("reset addr", bus.imem_addr_o, 32'h0);
      check("reset valid", bus.id_valid_o, 1'b0);
      check("reset pc", bus.id_pc_o, 32'h0);
      check("reset inst", bus.id_inst_o, 64'h0);

      for (int i = 0; i < 15; i++) begin
         drive(0, vt[i].stall, 0, 32'h0, vt[i].ack);
         expect_req($sformatf("vec%0d", i), vt[i].req, vt[i].addr);
         expect_head($sformatf("vec%0d", i), vt[i].valid, vt[i].pc);
         tick();
      end

      // Fill to two entries under stall, then flush while stalled.
      drive(0, 1, 0, 32'h0, 1); tick();
      expect_req("fill1", 1, 32'h38); expect_head("fill1", 1, 32'h30);
      drive(0, 1, 0, 32'h0, 1); tick();
      expect_req("full", 0, 32'h0); expect_head("full", 1, 32'h30);
      drive(0, 1, 1, 32'h200, 0); tick();
      expect_req("stallflush", 0, 32'h0); expect_head("stallflush", 0, 32'h0);
      drive(0, 0, 0, 32'h0, 0); tick();
      expect_req("redir", 1, 32'h200); expect_head("redir", 0, 32'h0);
      drive(0, 0, 0, 32'h0, 1); tick();
      expect_head("redir data", 1, 32'h200);

      // Flush with an ack pending: request held, late data dropped.
      drive(0, 0, 0, 32'h0, 0); tick();
      expect_req("pend", 1, 32'h208);
      drive(0, 0, 1, 32'h100, 0); tick();
      expect_req("disc1", 1, 32'h208); expect_head("disc1", 0, 32'h0);
      drive(0, 0, 0, 32'h0, 0); tick();
      expect_req("disc2", 1, 32'h208); expect_head("disc2", 0, 32'h0);
      drive(0, 0, 0, 32'h0, 1); tick();
      expect_req("disc ack", 0, 32'h0); expect_head("disc ack", 0, 32'h0);
      drive(0, 0, 0, 32'h0, 0); tick();
      expect_req("after disc", 1, 32'h100); expect_head("after disc", 0, 32'h0);
      drive(0, 0, 0, 32'h0, 1); tick();
      expect_head("flush data", 1, 32'h100);

      // Flush on the ack edge, then repeated flush while discarding.
      drive(0, 0, 1, 32'h300, 1); tick();
      expect_req("flushack", 0, 32'h0); expect_head("flushack", 0, 32'h0);
      drive(0, 0, 0, 32'h0, 0); tick();
      expect_req("flushack next", 1, 32'h300);
      drive(0, 0, 1, 32'h400, 0); tick();
      drive(0, 0, 1, 32'h500, 0); tick();
      expect_req("reflush", 1, 32'h300);
      drive(0, 0, 0, 32'h0, 1); tick();
      drive(0, 0, 0, 32'h0, 0); tick();
      expect_req("latest target", 1, 32'h500);

      // Reset overrides everything mid-stream.
      drive(0, 1, 0, 32'h0, 1); tick();
      expect_req("prerst", 1, 32'h508); expect_head("prerst", 1, 32'h500);
      drive(1, 1, 1, 32'h700, 1); tick();
      check("midrst req", bus.imem_req_o, 1'b0);
      check("midrst addr", bus.imem_addr_o, 32'h0);
      check("midrst valid", bus.id_valid_o, 1'b0);
      check("midrst pc", bus.id_pc_o, 32'h0);
      check("midrst inst", bus.id_inst_o, 64'h0);
      check("wrap rst req", wbus.imem_req_o, 1'b0);
      drive(0, 0, 0, 32'h0, 0); tick();
      expect_req("release", 1, 32'h0);
      check("wrap first req", wbus.imem_req_o, 1'b1);
      check("wrap first addr", wbus.imem_addr_o, 32'hFFFF_FFF8);
      tick();
      check("wrap second addr", wbus.imem_addr_o, 32'h0);
      check("wrap head pc", wbus.id_pc_o, 32'hFFFF_FFF8);
      check("wrap head valid", wbus.id_valid_o, 1'b1);

      // Randomized run: ID must see an unbroken PC stream restarting at each flush target.
      drive(1, 0, 0, 32'h0, 0); tick(); tick();
      drive(0, 0, 0, 32'h0, 0);
      exp_pc = 32'h0; prev_req = 0; prev_ack = 0; prev_addr = 0; lat = 0; pops = 0;
      for (int c = 0; c < 3000; c++) begin
         if (prev_req && !prev_ack) begin
            check("rand hold req", bus.imem_req_o, 1'b1);
            check("rand hold addr", bus.imem_addr_o, prev_addr);
         end
         if (bus.imem_req_o) begin
            if (!prev_req || prev_ack) lat = $urandom_range(0, 3);
            else if (lat != 0) lat--;
            a = (lat == 0);
         end else begin
            a = ($urandom_range(0, 7) == 0);
         end
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 31) == 0);
         r32 = $urandom();
         fp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : {r32[31:3], 3'b000};
         drive(0, s, f, fp, a);
         if (bus.id_valid_o && !s && !f) begin
            check("rand pc", bus.id_pc_o, exp_pc);
            check("rand inst", bus.id_inst_o, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd8;
            pops++;
         end
         if (f) exp_pc = fp;
         prev_req = bus.imem_req_o; prev_addr = bus.imem_addr_o; prev_ack = a;
         tick();
      end
      total++;
      if (pops < 200) begin
         bad++;
         $display("FAIL rand progress: got %0d pops want at least 200", pops);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
